// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared defaults and owner encoding for the memory-port arbiter.
package mem_arbiter_pkg;
   localparam int         DEF_ADDR_W     = 30;
   localparam int         DEF_FB_RUN_MAX = 8;
   localparam int         DEF_RUN_W      = 4;
   localparam logic [1:0] DEF_ID_FB      = 2'd3;
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_FB   = 2'd2
   } owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, framebuffer and ssram_ctrl bundles around the arbiter.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);
   logic [1:0]        cpu_id;
   logic [ADDR_W-1:0] cpu_address;
   logic              cpu_read;
   logic              cpu_write;
   logic [31:0]       cpu_writedata;
   logic [3:0]        cpu_writedatamask;
   logic              cpu_waitrequest;
   logic [ADDR_W-1:0] fb_address;
   logic              fb_read;
   logic              fb_waitrequest;
   logic [1:0]        mem_id;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic [3:0]        mem_writedatamask;
   logic              mem_waitrequest;
   modport slave (
      input  cpu_id, cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_writedatamask,
      input  fb_address, fb_read, mem_waitrequest,
      output cpu_waitrequest, fb_waitrequest,
      output mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
   );
   modport master (
      output cpu_id, cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_writedatamask,
      output fb_address, fb_read, mem_waitrequest,
      input  cpu_waitrequest, fb_waitrequest,
      input  mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the ssram_ctrl port between CPU and FB; FB priority with a grant lock
// under waitrequest and a run counter that forces a CPU slot after FB_RUN_MAX FB acceptances.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int         ADDR_W     = DEF_ADDR_W,
   parameter int         FB_RUN_MAX = DEF_FB_RUN_MAX,
   parameter int         RUN_W      = DEF_RUN_W,
   parameter logic [1:0] ID_FB      = DEF_ID_FB
) (
   input  logic         clock,
   input  logic         reset_n,
   mem_arbiter_if.slave bus,
   output logic [31:0]  fb_grant_cnt,
   output logic [31:0]  cpu_stall_cnt
);
   owner_e            sel, owner_q, owner_d;
   logic              locked_q, locked_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [31:0]       fb_cnt_q, fb_cnt_d, stall_cnt_q, stall_cnt_d;
   logic              cpu_req, sel_req, accept, at_max, cpu_wait;
   logic [ADDR_W-1:0] addr_mux;
   always_comb begin
      cpu_req = bus.cpu_read | bus.cpu_write;
      at_max  = run_q == RUN_W'(FB_RUN_MAX);
      // reset forces NONE so the port is idle while reset_n is low
      sel = !reset_n ? OWN_NONE :
            locked_q ? owner_q :
            (bus.fb_read & cpu_req & at_max) ? OWN_CPU :
            bus.fb_read ? OWN_FB :
            cpu_req ? OWN_CPU : OWN_NONE;
      sel_req  = ((sel == OWN_CPU) & cpu_req) | ((sel == OWN_FB) & bus.fb_read);
      accept   = sel_req & !bus.mem_waitrequest;
      cpu_wait = (sel != OWN_CPU) | bus.mem_waitrequest;
      addr_mux = (sel == OWN_FB) ? bus.fb_address : bus.cpu_address;
      locked_d = sel_req & bus.mem_waitrequest;
      owner_d  = locked_d ? sel : OWN_NONE;
      run_d    = run_q;
      if (accept & (sel == OWN_FB) & cpu_req)
         run_d = at_max ? run_q : run_q + 1'b1;
      else if ((accept & (sel == OWN_CPU)) | !cpu_req)
         run_d = '0;
      fb_cnt_d    = fb_cnt_q + {31'd0, accept & (sel == OWN_FB)};
      stall_cnt_d = stall_cnt_q + {31'd0, cpu_req & cpu_wait};
   end
   always_comb begin
      bus.cpu_waitrequest   = cpu_wait;
      bus.fb_waitrequest    = (sel != OWN_FB) | bus.mem_waitrequest;
      bus.mem_id            = (sel == OWN_FB) ? ID_FB : bus.cpu_id;
      bus.mem_address       = addr_mux;
      bus.mem_read          = (sel == OWN_FB) | ((sel == OWN_CPU) & bus.cpu_read);
      bus.mem_write         = (sel == OWN_CPU) & bus.cpu_write;
      bus.mem_writedata     = bus.cpu_writedata;
      bus.mem_writedatamask = bus.cpu_writedatamask;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         owner_q     <= OWN_NONE;
         locked_q    <= 1'b0;
         run_q       <= '0;
         fb_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         owner_q     <= owner_d;
         locked_q    <= locked_d;
         run_q       <= run_d;
         fb_cnt_q    <= fb_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
   assign fb_grant_cnt  = fb_cnt_q;
   assign cpu_stall_cnt = stall_cnt_q;
   // requesters must hold their request while stalled
   a_hold: assert property (@(posedge clock) disable iff (!reset_n) locked_q |-> sel_req)
      else $error("owner dropped its request under waitrequest");
   a_rw: assert property (@(posedge clock) disable iff (!reset_n) !(bus.cpu_read & bus.cpu_write))
      else $error("cpu_read and cpu_write both set");
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a per-cycle rule-level model and literal checks.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;
   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] fb_grant_cnt, cpu_stall_cnt;
   int          checks = 0;
   int          errors = 0;
   int          m_lock = 0;
   int          m_run = 0;
   logic [31:0] m_fb = '0;
   logic [31:0] m_stall = '0;
   logic [1:0]  acc_q[$];
   mem_arbiter_if #(.ADDR_W(30)) bus();
   mem_arbiter #(.ADDR_W(30), .FB_RUN_MAX(8), .RUN_W(4), .ID_FB(2'd3)) u_dut (
      .clock(clock), .reset_n(reset_n), .bus(bus),
      .fb_grant_cnt(fb_grant_cnt), .cpu_stall_cnt(cpu_stall_cnt)
   );
   always #5 clock = ~clock;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   // model: 0 none, 1 cpu, 2 fb
   always @(negedge clock) begin
      int   es;
      logic creq, ereq, ecw, efw, grant;
      if (!reset_n) begin
         m_lock = 0; m_run = 0; m_fb = '0; m_stall = '0;
      end
      creq = bus.cpu_read | bus.cpu_write;
      es = !reset_n ? 0 : (m_lock != 0) ? m_lock :
           (bus.fb_read && creq && m_run == 8) ? 1 : bus.fb_read ? 2 : creq ? 1 : 0;
      ereq = (es == 1 && creq) || (es == 2 && bus.fb_read);
      ecw = (es != 1) || bus.mem_waitrequest;
      efw = (es != 2) || bus.mem_waitrequest;
      chk("m_read", {31'd0, bus.mem_read}, {31'd0, es == 2 || (es == 1 && bus.cpu_read)});
      chk("m_write", {31'd0, bus.mem_write}, {31'd0, es == 1 && bus.cpu_write});
      chk("m_cpu_wait", {31'd0, bus.cpu_waitrequest}, {31'd0, ecw});
      chk("m_fb_wait", {31'd0, bus.fb_waitrequest}, {31'd0, efw});
      chk("m_fb_cnt", fb_grant_cnt, m_fb);
      chk("m_stall_cnt", cpu_stall_cnt, m_stall);
      if (es != 0) begin
         chk("m_id", {30'd0, bus.mem_id}, (es == 2) ? 32'd3 : {30'd0, bus.cpu_id});
         chk("m_addr", {2'd0, bus.mem_address}, {2'd0, (es == 2) ? bus.fb_address : bus.cpu_address});
      end
      if (es == 1 && bus.cpu_write) begin
         chk("m_wdata", bus.mem_writedata, bus.cpu_writedata);
         chk("m_mask", {28'd0, bus.mem_writedatamask}, {28'd0, bus.cpu_writedatamask});
      end
      if (reset_n) begin
         grant = ereq && !bus.mem_waitrequest;
         if (grant && es == 2) m_fb = m_fb + 1;
         if (creq && ecw) m_stall = m_stall + 1;
         if (grant && es == 2 && creq) m_run = (m_run < 8) ? m_run + 1 : 8;
         else if ((grant && es == 1) || !creq) m_run = 0;
         m_lock = (ereq && bus.mem_waitrequest) ? es : 0;
         if ((bus.mem_read || bus.mem_write) && !bus.mem_waitrequest) acc_q.push_back(bus.mem_id);
      end
   end
   initial begin
      int          wcnt, fbw;
      logic [31:0] wdata, waddr;
      logic [3:0]  wmask;
      reset_n = 1'b0;
      bus.cpu_id = 2'd1; bus.cpu_address = '0; bus.cpu_read = 1'b1; bus.cpu_write = 1'b0;
      bus.cpu_writedata = '0; bus.cpu_writedatamask = '0;
      bus.fb_address = 30'h1000; bus.fb_read = 1'b1; bus.mem_waitrequest = 1'b0;
      // reset holds the port idle even with both requesting
      repeat (3) @(negedge clock);
      chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
      chk("rst_cpu_wait", {31'd0, bus.cpu_waitrequest}, 32'd1);
      chk("rst_fb_wait", {31'd0, bus.fb_waitrequest}, 32'd1);
      chk("rst_fb_cnt", fb_grant_cnt, 32'd0);
      chk("rst_stall_cnt", cpu_stall_cnt, 32'd0);
      @(posedge clock); #1 reset_n = 1'b1; #1;
      chk("rel_id", {30'd0, bus.mem_id}, 32'd3);
      chk("rel_addr", {2'd0, bus.mem_address}, 32'h1000);
      chk("rel_fb_wait", {31'd0, bus.fb_waitrequest}, 32'd0);
      step();
      bus.cpu_read = 1'b0; bus.fb_read = 1'b0;
      step();
      // lock: CPU stalled 3 cycles, FB arrives in cycle 1
      bus.cpu_id = 2'd2; bus.cpu_address = 30'h100; bus.cpu_read = 1'b1; bus.mem_waitrequest = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) bus.fb_read = 1'b1;
         if (c == 3) bus.mem_waitrequest = 1'b0;
         @(negedge clock);
         chk("lock_addr", {2'd0, bus.mem_address}, 32'h100);
         chk("lock_id", {30'd0, bus.mem_id}, 32'd2);
         chk("lock_cpu_wait", {31'd0, bus.cpu_waitrequest}, (c < 3) ? 32'd1 : 32'd0);
         step();
      end
      bus.cpu_read = 1'b0;
      @(negedge clock);
      chk("lock_fb_next_id", {30'd0, bus.mem_id}, 32'd3);
      chk("lock_fb_next_wait", {31'd0, bus.fb_waitrequest}, 32'd0);
      step();
      bus.fb_read = 1'b0;
      step();
      // starvation guard: 8 FB, 1 CPU, then FB resumes
      bus.cpu_id = 2'd1; bus.cpu_address = 30'h200; bus.cpu_read = 1'b1;
      bus.fb_address = 30'h300; bus.fb_read = 1'b1;
      acc_q.delete();
      repeat (9) step();
      bus.cpu_read = 1'b0;
      repeat (2) step();
      bus.fb_read = 1'b0;
      chk("starve_len", acc_q.size(), 32'd11);
      for (int i = 0; i < 11 && i < acc_q.size(); i++)
         chk($sformatf("starve_acc%0d", i), {30'd0, acc_q[i]}, (i == 8) ? 32'd1 : 32'd3);
      step();
      // CPU idle: counters from a fresh reset
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      bus.fb_read = 1'b1;
      repeat (100) step();
      bus.fb_read = 1'b0;
      @(negedge clock);
      chk("idle_fb_cnt", fb_grant_cnt, 32'd100);
      chk("idle_stall_cnt", cpu_stall_cnt, 32'd0);
      step();
      // write isolation
      bus.cpu_address = 30'h40; bus.cpu_write = 1'b1;
      bus.cpu_writedata = 32'hDEADBEEF; bus.cpu_writedatamask = 4'b0101; bus.fb_read = 1'b1;
      wcnt = 0; fbw = 0; wdata = '0; waddr = '0; wmask = '0;
      for (int c = 0; c < 11; c++) begin
         @(negedge clock);
         if (bus.mem_write) begin
            wcnt++; wdata = bus.mem_writedata; wmask = bus.mem_writedatamask;
            waddr = {2'd0, bus.mem_address};
         end
         if (bus.mem_id == 2'd3 && bus.mem_read && bus.mem_write) fbw++;
         step();
         if (c == 8) bus.cpu_write = 1'b0;
      end
      bus.fb_read = 1'b0;
      chk("wr_cycles", wcnt, 32'd1);
      chk("wr_data", wdata, 32'hDEADBEEF);
      chk("wr_mask", {28'd0, wmask}, 32'd5);
      chk("wr_addr", waddr, 32'h40);
      chk("wr_on_fb", fbw, 32'd0);
      step();
      // async reset while CPU is locked
      bus.cpu_id = 2'd1; bus.cpu_address = 30'h80; bus.cpu_read = 1'b1; bus.mem_waitrequest = 1'b1;
      step();
      bus.fb_read = 1'b1;
      #1;
      chk("arst_locked_id", {30'd0, bus.mem_id}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_mem_read", {31'd0, bus.mem_read}, 32'd0);
      chk("arst_cpu_wait", {31'd0, bus.cpu_waitrequest}, 32'd1);
      chk("arst_fb_wait", {31'd0, bus.fb_waitrequest}, 32'd1);
      @(posedge clock);
      #1 bus.mem_waitrequest = 1'b0; reset_n = 1'b1;
      #1;
      chk("arst_unlocked_id", {30'd0, bus.mem_id}, 32'd3);
      chk("arst_unlocked_read", {31'd0, bus.mem_read}, 32'd1);
      step();
      bus.cpu_read = 1'b0; bus.fb_read = 1'b0;
      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
